mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: MEM_stage

---
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Holds one instruction from EXE,
//                waits for the data-SRAM response of loads/stores, aligns and
//                extends load data, and hands the instruction on to WB.
//                A flush from WB that hits an outstanding request leaves a
//                response in flight; that response is discarded when it
//                arrives so that a younger instruction cannot consume it.
//  Ports       : clk, resetn            - clock / async active-low reset
//                es_to_ms_valid/bus     - instruction from EXE (179 bits)
//                ms_allowin             - MEM can accept from EXE
//                data_sram_data_ok/rdata- data-SRAM response strobe / data
//                ws_allowin             - WB can accept from MEM
//                ms_to_ws_valid/bus     - instruction to WB (174 bits)
//                ms_reflush             - flush request from WB
//                ms_to_ds_dest/value    - forwarding to decode
//                ms_ld_block            - load result not yet available
//                ms_csr                 - CSR-type instruction in MEM
//                ms_ex_to_es            - exception/ertn in MEM (stop stores)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         es_to_ms_valid,
    input  logic [178:0] es_to_ms_bus,
    output logic         ms_allowin,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [173:0] ms_to_ws_bus,
    input  logic         ms_reflush,
    output logic [4:0]   ms_to_ds_dest,
    output logic [31:0]  ms_to_ds_value,
    output logic         ms_ld_block,
    output logic         ms_csr,
    output logic         ms_ex_to_es
);

    // Request state of the instruction held in this stage.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    logic         r_valid;
    logic [178:0] r_bus;
    state_t       r_state;
    logic         r_discard;
    logic [31:0]  r_data_buf;

    // Field views of the held instruction.
    logic        w_mem_req;
    logic        w_ld_en;
    logic [1:0]  w_ld_size;
    logic        w_ld_unsigned;
    logic [173:0] w_payload;
    logic        w_ertn;
    logic        w_csr_we;
    logic        w_csr_rd;
    logic [16:0] w_ex_cause;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_result;

    // Field views of the incoming instruction (used to pick the entry state).
    logic        w_in_mem_req;
    logic [16:0] w_in_ex_cause;

    logic        w_accept;
    logic        w_data_ok_mine;
    logic        w_ready_go;
    logic        w_discard_next;
    state_t      w_entry_state;

    logic [31:0] w_rdata_src;
    logic [1:0]  w_offset;
    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;
    logic [7:0]  w_byte_lane;
    logic [15:0] w_half_lane;
    logic [31:0] w_ld_value;
    logic [31:0] w_final_value;

    assign w_mem_req     = r_bus[178];
    assign w_ld_en       = r_bus[177];
    assign w_ld_size     = r_bus[176:175];
    assign w_ld_unsigned = r_bus[174];
    assign w_payload     = r_bus[173:0];
    assign w_ertn        = r_bus[135];
    assign w_csr_we      = r_bus[134];
    assign w_csr_rd      = r_bus[133];
    assign w_ex_cause    = r_bus[86:70];
    assign w_gr_we       = r_bus[69];
    assign w_dest        = r_bus[68:64];
    assign w_result      = r_bus[63:32];

    assign w_in_mem_req  = es_to_ms_bus[178];
    assign w_in_ex_cause = es_to_ms_bus[86:70];

    // A response strobe belongs to the current instruction only when no
    // orphaned response from a flushed instruction is still outstanding.
    assign w_data_ok_mine = data_sram_data_ok && !r_discard;

    assign w_ready_go = (r_state == S_DONE) ||
                        ((r_state == S_WAIT) && w_data_ok_mine);

    assign ms_allowin     = !r_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_valid && w_ready_go;

    assign w_accept = es_to_ms_valid && ms_allowin;

    // Only a fault-free memory access actually issues a request.
    assign w_entry_state = (w_in_mem_req && (w_in_ex_cause == 17'd0)) ? S_WAIT : S_DONE;

    // Flushing while waiting orphans the in-flight response. If the response
    // arrives in the flush cycle itself it is consumed there and nothing is
    // left to drop. An orphan that arrives clears the flag.
    always_comb begin
        w_discard_next = r_discard;
        if (ms_reflush && (r_state == S_WAIT) && !w_data_ok_mine) begin
            w_discard_next = 1'b1;
        end else if (data_sram_data_ok && r_discard) begin
            w_discard_next = 1'b0;
        end
    end

    // Bypass the live response in the cycle it arrives; afterwards use the
    // buffered copy so the data survives WB back-pressure.
    assign w_rdata_src  = (r_state == S_DONE) ? r_data_buf : data_sram_rdata;
    assign w_offset     = w_result[1:0];
    assign w_byte_shift = w_rdata_src >> {w_offset, 3'b000};
    assign w_half_shift = w_rdata_src >> {w_offset[1], 4'b0000};
    assign w_byte_lane  = w_byte_shift[7:0];
    assign w_half_lane  = w_half_shift[15:0];

    always_comb begin
        w_ld_value = w_rdata_src;
        if (w_ld_size == c_SIZE_BYTE) begin
            w_ld_value = w_ld_unsigned ? {24'd0, w_byte_lane}
                                       : {{24{w_byte_lane[7]}}, w_byte_lane};
        end else if (w_ld_size == c_SIZE_HALF) begin
            w_ld_value = w_ld_unsigned ? {16'd0, w_half_lane}
                                       : {{16{w_half_lane[15]}}, w_half_lane};
        end
    end

    assign w_final_value = w_ld_en ? w_ld_value : w_result;

    assign ms_to_ws_bus   = {w_payload[173:64], w_final_value, w_payload[31:0]};
    assign ms_to_ds_dest  = (r_valid && w_gr_we) ? w_dest : 5'd0;
    assign ms_to_ds_value = (r_valid && w_gr_we) ? w_final_value : 32'd0;
    assign ms_ld_block    = r_valid && w_ld_en && !w_ready_go;
    assign ms_csr         = r_valid && (w_csr_we || w_csr_rd || w_ertn);
    assign ms_ex_to_es    = r_valid && ((|w_ex_cause[15:0]) || w_ertn);

    // Reset release is expected to be synchronized by the enclosing top level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid    <= 1'b0;
            r_bus      <= '0;
            r_state    <= S_IDLE;
            r_discard  <= 1'b0;
            r_data_buf <= 32'd0;
        end else begin
            r_discard <= w_discard_next;

            if (w_accept) begin
                r_bus <= es_to_ms_bus;
            end

            if (ms_reflush) begin
                r_valid <= 1'b0;
                r_state <= S_IDLE;
            end else if (ms_allowin) begin
                r_valid <= es_to_ms_valid;
                r_state <= w_accept ? w_entry_state : S_IDLE;
            end else if ((r_state == S_WAIT) && w_data_ok_mine) begin
                r_state    <= S_DONE;
                r_data_buf <= data_sram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         es_to_ms_valid;
    logic [178:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [173:0] ms_to_ws_bus;
    logic         ms_reflush;
    logic [4:0]   ms_to_ds_dest;
    logic [31:0]  ms_to_ds_value;
    logic         ms_ld_block;
    logic         ms_csr;
    logic         ms_ex_to_es;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_reflush        (ms_reflush),
        .ms_to_ds_dest     (ms_to_ds_dest),
        .ms_to_ds_value    (ms_to_ds_value),
        .ms_ld_block       (ms_ld_block),
        .ms_csr            (ms_csr),
        .ms_ex_to_es       (ms_ex_to_es)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an EXE->MEM bus word.
    function automatic logic [178:0] mk(input logic mem_req, input logic ld_en,
                                        input logic [1:0] size, input logic uns,
                                        input logic [16:0] exc, input logic ertn,
                                        input logic csr_we, input logic gr_we,
                                        input logic [4:0] dest, input logic [31:0] result,
                                        input logic [31:0] pc);
        mk = {mem_req, ld_en, size, uns,
              5'h15, 1'b0, result ^ 32'h5A5A_0000, ertn, csr_we, 1'b0,
              32'hF0F0_0F0F, 14'h0123, exc, gr_we, dest, result, pc};
    endfunction

    // Inputs change 1 time unit after the rising edge; checks 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        ws_allowin = 1'b1; ms_reflush = 1'b0;
        step(); step(); settle();
        n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %b want 1", ms_allowin); end
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ws_valid got %b want 0", ms_to_ws_valid); end
        n_cmp++; if ({ms_to_ds_dest, ms_to_ds_value, ms_ld_block, ms_csr, ms_ex_to_es} !== 40'd0) begin
            n_fail++; $display("FAIL reset_outs got dest=%h val=%h blk=%b csr=%b ex=%b want all 0",
                               ms_to_ds_dest, ms_to_ds_value, ms_ld_block, ms_csr, ms_ex_to_es); end
        step();
        resetn = 1'b1;
        step();
    endtask

    // ld.b, offset 3, response two cycles after entering MEM.
    task automatic test_ld_b_wait();
        logic [178:0] b;
        b = mk(1'b1, 1'b1, 2'b00, 1'b0, 17'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0010);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b;
        settle();
        n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL ldb_accept_allowin got %b want 1", ms_allowin); end
        step(); es_to_ms_valid = 1'b0; settle();
        n_cmp++; if ({ms_ld_block, ms_to_ws_valid} !== 2'b10) begin n_fail++; $display("FAIL ldb_block_c1 got blk=%b v=%b want 1 0", ms_ld_block, ms_to_ws_valid); end
        step(); settle();
        n_cmp++; if ({ms_ld_block, ms_to_ws_valid} !== 2'b10) begin n_fail++; $display("FAIL ldb_block_c2 got blk=%b v=%b want 1 0", ms_ld_block, ms_to_ws_valid); end
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8000_0000; settle();
        n_cmp++; if ({ms_ld_block, ms_to_ws_valid} !== 2'b01) begin n_fail++; $display("FAIL ldb_done got blk=%b v=%b want 0 1", ms_ld_block, ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus !== {b[173:64], 32'hFFFF_FF80, b[31:0]}) begin n_fail++; $display("FAIL ldb_bus got %h want result FFFFFF80", ms_to_ws_bus); end
        n_cmp++; if ({ms_to_ds_dest, ms_to_ds_value} !== {5'd7, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL ldb_fwd got %h/%h want 07/FFFFFF80", ms_to_ds_dest, ms_to_ds_value); end
        step(); data_sram_data_ok = 1'b0; settle();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_retired got %b want 0", ms_to_ws_valid); end
    endtask

    // ld.hu, offset 2, response in the first cycle in MEM.
    task automatic test_ld_hu_bypass();
        logic [178:0] b;
        b = mk(1'b1, 1'b1, 2'b01, 1'b1, 17'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_2002, 32'h1C00_0020);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b;
        step(); es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_1234; settle();
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL hu_valid got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h0000_8001) begin n_fail++; $display("FAIL hu_value got %h want 00008001", ms_to_ws_bus[63:32]); end
        step(); data_sram_data_ok = 1'b0; settle();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL hu_retired got %b want 0", ms_to_ws_valid); end
    endtask

    // Flush while waiting: the orphaned response must not complete the next load.
    task automatic test_flush_discard();
        logic [178:0] b1, b2;
        b1 = mk(1'b1, 1'b1, 2'b10, 1'b0, 17'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_3000, 32'h1C00_0030);
        b2 = mk(1'b1, 1'b1, 2'b10, 1'b0, 17'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_3004, 32'h1C00_0034);
        es_to_ms_valid = 1'b1; es_to_ms_bus = b1;
        step(); es_to_ms_valid = 1'b0;
        ms_reflush = 1'b1;
        step(); ms_reflush = 1'b0; settle();
        n_cmp++; if ({ms_allowin, ms_to_ws_valid, ms_ld_block} !== 3'b100) begin n_fail++; $display("FAIL flush_cleared got a=%b v=%b blk=%b want 1 0 0", ms_allowin, ms_to_ws_valid, ms_ld_block); end
        es_to_ms_valid = 1'b1; es_to_ms_bus = b2;
        step(); es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0001; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_ld_block} !== 2'b01) begin n_fail++; $display("FAIL flush_drop got v=%b blk=%b want 0 1", ms_to_ws_valid, ms_ld_block); end
        step(); data_sram_data_ok = 1'b0; settle();
        n_cmp++; if (ms_ld_block !== 1'b1) begin n_fail++; $display("FAIL flush_still_wait got %b want 1", ms_ld_block); end
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBBBB_0002; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_to_ws_bus[63:32]} !== {1'b1, 32'hBBBB_0002}) begin n_fail++; $display("FAIL flush_b got v=%b val=%h want 1 BBBB0002", ms_to_ws_valid, ms_to_ws_bus[63:32]); end
        step(); data_sram_data_ok = 1'b0;
    endtask

    // WB back-pressure: captured data must survive a changing rdata.
    task automatic test_backpressure();
        logic [178:0] b;
        b = mk(1'b1, 1'b1, 2'b10, 1'b0, 17'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_4000, 32'h1C00_0040);
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = b;
        step(); es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_allowin} !== 2'b10) begin n_fail++; $display("FAIL bp_arrive got v=%b a=%b want 1 0", ms_to_ws_valid, ms_allowin); end
        for (int i = 0; i < 2; i++) begin
            step(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678; settle();
            n_cmp++; if ({ms_allowin, ms_to_ws_bus[63:32]} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL bp_hold%0d got a=%b val=%h want 0 DEADBEEF", i, ms_allowin, ms_to_ws_bus[63:32]); end
        end
        step(); ws_allowin = 1'b1; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]} !== {2'b11, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL bp_release got v=%b a=%b val=%h want 1 1 DEADBEEF", ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]); end
        step(); settle();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL bp_retired got %b want 0", ms_to_ws_valid); end
    endtask

    // Faulting memory instruction goes straight to DONE.
    task automatic test_exception();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b1, 1'b1, 2'b10, 1'b0, 17'h0_0004, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_5000, 32'h1C00_0050);
        step(); es_to_ms_valid = 1'b0; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_ex_to_es, ms_ld_block} !== 3'b110) begin n_fail++; $display("FAIL exc got v=%b ex=%b blk=%b want 1 1 0", ms_to_ws_valid, ms_ex_to_es, ms_ld_block); end
        step(); settle();
        n_cmp++; if ({ms_to_ws_valid, ms_ex_to_es} !== 2'b00) begin n_fail++; $display("FAIL exc_retired got v=%b ex=%b want 0 0", ms_to_ws_valid, ms_ex_to_es); end
    endtask

    // Store waits for data_ok; rdata ignored; no register write.
    task automatic test_store();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b1, 1'b0, 2'b10, 1'b0, 17'd0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_1234, 32'h1C00_0060);
        step(); es_to_ms_valid = 1'b0; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_ld_block, ms_allowin} !== 3'b000) begin n_fail++; $display("FAIL st_wait got v=%b blk=%b a=%b want 0 0 0", ms_to_ws_valid, ms_ld_block, ms_allowin); end
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ds_dest} !== {1'b1, 32'h0000_1234, 5'd0}) begin n_fail++; $display("FAIL st_done got v=%b val=%h dest=%h want 1 00001234 00", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ds_dest); end
        step(); data_sram_data_ok = 1'b0;
    endtask

    // Two non-memory instructions back to back: ertn then CSR write.
    task automatic test_back_to_back();
        logic [178:0] b2;
        b2 = mk(1'b0, 1'b0, 2'b00, 1'b0, 17'd0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hCAFE_0000, 32'h1C00_0074);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b0, 1'b0, 2'b00, 1'b0, 17'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0070);
        step(); es_to_ms_bus = b2; settle();
        n_cmp++; if ({ms_csr, ms_ex_to_es, ms_to_ws_valid, ms_allowin} !== 4'b1111) begin n_fail++; $display("FAIL b2b_ertn got csr=%b ex=%b v=%b a=%b want 1111", ms_csr, ms_ex_to_es, ms_to_ws_valid, ms_allowin); end
        step(); es_to_ms_valid = 1'b0; settle();
        n_cmp++; if ({ms_csr, ms_ex_to_es, ms_to_ds_dest, ms_to_ds_value} !== {2'b10, 5'd9, 32'hCAFE_0000}) begin n_fail++; $display("FAIL b2b_csr got csr=%b ex=%b dest=%h val=%h want 1 0 09 CAFE0000", ms_csr, ms_ex_to_es, ms_to_ds_dest, ms_to_ds_value); end
        n_cmp++; if (ms_to_ws_bus !== b2[173:0]) begin n_fail++; $display("FAIL b2b_bus got %h want %h", ms_to_ws_bus, b2[173:0]); end
        step(); settle();
        n_cmp++; if ({ms_to_ws_valid, ms_csr} !== 2'b00) begin n_fail++; $display("FAIL b2b_empty got v=%b csr=%b want 0 0", ms_to_ws_valid, ms_csr); end
    endtask

    // Asynchronous reset while a load waits; late response must be ignored.
    task automatic test_reset_mid_wait();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b1, 1'b1, 2'b10, 1'b0, 17'd0, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_6000, 32'h1C00_0080);
        step(); es_to_ms_valid = 1'b0; settle();
        n_cmp++; if (ms_ld_block !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wait got %b want 1", ms_ld_block); end
        #2 resetn = 1'b0; #1;
        n_cmp++; if ({ms_allowin, ms_to_ws_valid, ms_ld_block, ms_csr, ms_ex_to_es} !== 5'b10000) begin n_fail++; $display("FAIL rst_async got a=%b v=%b blk=%b csr=%b ex=%b want 1 0 0 0 0", ms_allowin, ms_to_ws_valid, ms_ld_block, ms_csr, ms_ex_to_es); end
        n_cmp++; if ({ms_to_ds_dest, ms_to_ds_value} !== 37'd0) begin n_fail++; $display("FAIL rst_async_fwd got %h/%h want 0/0", ms_to_ds_dest, ms_to_ds_value); end
        step(); resetn = 1'b1;
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555; settle();
        n_cmp++; if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin n_fail++; $display("FAIL rst_stale got v=%b a=%b want 0 1", ms_to_ws_valid, ms_allowin); end
        step(); data_sram_data_ok = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ld_b_wait();
        test_ld_hu_bypass();
        test_flush_discard();
        test_backpressure();
        test_exception();
        test_store();
        test_back_to_back();
        test_reset_mid_wait();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
